r_drain: RTL and testbench

R_DRAIN -- requirements
Module: r_drain

---
 rtl/r_drain_pkg.sv | 29 ++
 rtl/r_drain_if.sv | 23 ++
 rtl/r_drain.sv | 82 ++++++++
 tb/tb_r_drain.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/r_drain_pkg.sv
// rtl/r_drain_pkg.sv - shared types and constants for the FIFO read-side output buffer
package r_drain_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } buf_state_t;

    function automatic logic [1:0] held_of(input buf_state_t s);
        case (s)
            S_ONE:   return 2'd1;
            S_TWO:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic buf_state_t state_of(input logic [1:0] n);
        case (n)
            2'd0:    return S_EMPTY;
            2'd1:    return S_ONE;
            default: return S_TWO;
        endcase
    endfunction

endpackage

// File: rtl/r_drain_if.sv
// rtl/r_drain_if.sv - FIFO read port plus downstream valid/ready stream of the drain block
interface r_drain_if #(
    parameter int DATA_W = r_drain_pkg::DATA_W_DEF
);
    logic              empty;
    logic [DATA_W-1:0] r_data;
    logic              flush;
    logic              out_ready;
    logic              r_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [15:0]       word_count;

    modport master (
        input  empty, r_data, flush, out_ready,
        output r_en, out_data, out_valid, word_count
    );

    modport slave (
        output empty, r_data, flush, out_ready,
        input  r_en, out_data, out_valid, word_count
    );
endinterface

// File: rtl/r_drain.sv
// rtl/r_drain.sv - turns the latency-1 FIFO read port into a valid/ready stream via a 2-entry buffer
module r_drain
    import r_drain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic      r_clk,
    input  logic      n_rst,
    r_drain_if.master bus
);

    buf_state_t        state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic [1:0] held;
    logic [1:0] after_pop;
    logic [2:0] occ;
    logic       out_valid;
    logic       pop;
    logic       r_en;

    always_comb begin
        held      = held_of(state_q);
        out_valid = (state_q != S_EMPTY);
        pop       = out_valid & bus.out_ready & ~bus.flush;
        after_pop = held - {1'b0, pop};
        // Words held plus the one still coming out of the RAM must fit in two slots.
        occ       = {1'b0, held} + {2'b0, inflight_q} - {2'b0, pop};
        r_en      = n_rst & ~bus.empty & ~bus.flush & (occ <= 3'd1);
    end

    always_comb begin
        state_d      = state_q;
        inflight_d   = r_en;
        head_d       = head_q;
        tail_d       = tail_q;
        word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, pop};

        if (bus.flush) begin
            state_d    = S_EMPTY;
            inflight_d = 1'b0;
        end else begin
            if (pop && held == 2'd2) begin
                head_d = tail_q;
            end
            // The arriving word lands behind whatever survives this edge's pop.
            if (inflight_q) begin
                if (after_pop == 2'd0) begin
                    head_d = bus.r_data;
                end else begin
                    tail_d = bus.r_data;
                end
            end
            state_d = state_of(after_pop + {1'b0, inflight_q});
        end
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_EMPTY;
            inflight_q   <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.r_en       = r_en;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = head_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_r_drain.sv
// tb/tb_r_drain.sv - directed self-checking bench for r_drain with a latency-1 FIFO model
module tb_r_drain;

    logic r_clk;
    logic n_rst;
    logic flush;
    logic out_ready;
    logic empty_force;
    logic src_inf;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    logic [7:0] got [$];

    int n_errs = 0;
    int n_checks = 0;

    r_drain_if #(.DATA_W(8)) bus ();

    r_drain #(.DATA_W(8)) dut (
        .r_clk (r_clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    assign bus.flush     = flush;
    assign bus.out_ready = out_ready;
    assign bus.empty     = empty_force | (!src_inf && (rd_ptr == wr_ptr));

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // FIFO RAM: data appears the cycle after the accepted read
    always @(posedge r_clk) begin
        if (bus.r_en && !bus.empty) begin
            bus.r_data <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    always @(posedge r_clk) begin
        if (n_rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            pop_cnt <= pop_cnt + 1;
            if (!src_inf) got.push_back(bus.out_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    task automatic check_got(input string tag, input logic [7:0] base, input int n);
        check({tag, "_n"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), got[i], base + i[7:0]);
        end
    endtask

    logic r_en_exp  [0:5] = '{1, 1, 1, 0, 0, 0};
    logic valid_exp [0:5] = '{0, 0, 1, 1, 1, 0};
    logic [7:0] data_exp [0:5] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

    initial begin
        int k;
        int base_pops;
        n_rst       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        empty_force = 1'b0;
        src_inf     = 1'b0;
        bus.r_data  = 8'h00;

        // Basic three-word read
        push(8'h11); push(8'h22); push(8'h33);
        repeat (2) @(negedge r_clk);
        #1;
        check("rst_r_en", bus.r_en, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_wc", bus.word_count, 0);

        @(negedge r_clk);
        n_rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge r_clk);
            #1;
            check($sformatf("basic_r_en_c%0d", c), bus.r_en, r_en_exp[c]);
            check($sformatf("basic_valid_c%0d", c), bus.out_valid, valid_exp[c]);
            if (valid_exp[c]) check($sformatf("basic_data_c%0d", c), bus.out_data, data_exp[c]);
        end
        check("basic_wc", bus.word_count, 3);

        // Backpressure: stall for five cycles with A2 at the head
        @(negedge r_clk);
        got.delete();
        for (int i = 0; i < 10; i++) push(8'hA0 + i[7:0]);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge r_clk);
            out_ready = !(c >= 4 && c <= 8);
            #1;
            if (c == 0) check("bp_r_en_c0", bus.r_en, 1);
            if (c >= 4 && c <= 8) begin
                check($sformatf("bp_r_en_c%0d", c), bus.r_en, 0);
                check($sformatf("bp_valid_c%0d", c), bus.out_valid, 1);
                check($sformatf("bp_data_c%0d", c), bus.out_data, 8'hA2);
            end
        end
        repeat (15) @(negedge r_clk);
        #1;
        check_got("bp", 8'hA0, 10);
        check("bp_wc", bus.word_count, 13);

        // Flush while two words held and nothing in flight
        @(negedge r_clk);
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hB0 + i[7:0]);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge r_clk);
            flush = (c == 3);
            out_ready = (c == 4);
            #1;
            if (c == 3) begin
                check("fl_r_en", bus.r_en, 0);
                check("fl_valid_before", bus.out_valid, 1);
                check("fl_data_before", bus.out_data, 8'hB0);
            end
            if (c == 4) begin
                check("fl_valid_after", bus.out_valid, 0);
                check("fl_wc", bus.word_count, 13);
            end
        end
        repeat (10) @(negedge r_clk);
        #1;
        check_got("fl", 8'hB2, 2);
        check("fl_wc_end", bus.word_count, 15);

        // Empty toggling every cycle
        @(negedge r_clk);
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(8'hC0 + i[7:0]);
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge r_clk);
            empty_force = c[0];
        end
        empty_force = 1'b0;
        repeat (5) @(negedge r_clk);
        #1;
        check_got("tog", 8'hC0, 6);
        check("tog_wc", bus.word_count, 21);

        // Asynchronous reset while two words held
        @(negedge r_clk);
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hD0 + i[7:0]);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge r_clk);
            #1;
        end
        check("rm_valid_before", bus.out_valid, 1);
        check("rm_data_before", bus.out_data, 8'hD0);
        #2;
        n_rst = 1'b0;
        #1;
        check("rm_valid", bus.out_valid, 0);
        check("rm_r_en", bus.r_en, 0);
        check("rm_wc", bus.word_count, 0);
        check("rm_data", bus.out_data, 0);
        repeat (2) @(negedge r_clk);
        n_rst = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge r_clk);
        #1;
        check_got("rm", 8'hD2, 2);
        check("rm_wc_end", bus.word_count, 2);

        // word_count wrap with an endless source
        src_inf = 1'b1;
        base_pops = pop_cnt;
        k = 0;
        while (bus.word_count !== 16'hFFFF && k < 70000) begin
            @(negedge r_clk);
            k++;
        end
        check("wrap_reach", bus.word_count, 16'hFFFF);
        check("wrap_pops", pop_cnt - base_pops, 65533);
        @(negedge r_clk);
        #1;
        check("wrap_zero", bus.word_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
